wb_des_ctrl: RTL and testbench
==============================

WB_DES_CTRL -- requirements
Module: wb_des_ctrl

Interface
REQ-001 Parameter BASE_ADDR, default 32'h3000_0000, word-aligned base of the 32-byte register window.
REQ-002 wb_clk_i  in  1  sole clock; all logic on rising edge.
REQ-003 wb_rst_i  in  1  reset, synchronous, active-high.
REQ-004 wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  Wishbone classic slave request.
REQ-005 wbs_sel_i  in  4  byte lanes; wbs_adr_i  in  32  byte address; wbs_dat_i  in  32  write data.
REQ-006 wbs_ack_o  out  1  transfer ack; wbs_dat_o  out  32  read data.
REQ-007 des_key_o  out  64  key, des_data_o  out  64  input block, des_decrypt_o  out  1  mode, to DES core.
REQ-008 des_start_o  out  1  one-cycle start pulse to the core; des_done_i  in  1  one-cycle completion pulse; des_result_i  in  64  core output, valid when des_done_i=1.
REQ-009 irq_o  out  1  completion interrupt (present only per REQ-027).

Function
REQ-010 Select = cyc & stb & adr[31:5]==BASE_ADDR[31:5]; register offset = adr[4:2].
REQ-011 Map: 0 KEY_LO, 1 KEY_HI, 2 DIN_LO, 3 DIN_HI, 4 CTRL, 5 STATUS, 6 DOUT_LO, 7 DOUT_HI; LO = bits[31:0].
REQ-012 Ack one cycle after select, high exactly one cycle; a select held on the ack cycle is not re-acked; next request accepted the cycle after ack falls.
REQ-013 Writes honour wbs_sel_i per byte; reads return full words; wbs_dat_o = 0 when ack low.
REQ-014 CTRL: bit0 START (write-1, reads 0), bit1 DECRYPT, bit2 IE; other bits read 0.
REQ-015 STATUS: bit0 BUSY (read-only), bit1 DONE (sticky, write-1-clear); others 0.
REQ-016 DOUT_LO/HI read-only; writes acked, ignored.
REQ-017 FSM states IDLE, START, WAIT.
REQ-018 IDLE -> START on write of CTRL with START=1 and sel[0]=1; DONE cleared same edge.
REQ-019 START: des_start_o=1 for exactly this one cycle; -> WAIT.
REQ-020 WAIT -> IDLE on des_done_i; DOUT <= des_result_i, DONE <= 1 same edge.
REQ-021 BUSY = 1 in START and WAIT.
REQ-022 While BUSY: writes to KEY, DIN, CTRL.DECRYPT and START are acked but ignored; reads normal.
REQ-023 des_done_i in IDLE or START ignored; DONE W1C on the same edge as completion: set wins.
REQ-024 des_key_o, des_data_o, des_decrypt_o driven directly from registers.

Reset
REQ-025 On wb_rst_i: FSM IDLE; all registers, DOUT, DONE, IE, DECRYPT = 0; wbs_ack_o, des_start_o, irq_o = 0; reset mid-WAIT abandons operation, later des_done_i ignored.

Configuration
REQ-026 Macro WB_DES_IRQ_EN selects interrupt support.
REQ-027 Defined: irq_o = DONE & IE, registered. Undefined: irq_o tied 0, CTRL.IE reads 0, writes ignored.

Structure
REQ-028 Package wb_des_pkg: register offsets, CTRL/STATUS bit indices, FSM state encoding, BASE_ADDR default.
REQ-029 Sub-module wb_des_regfile (byte-enabled register storage); FSM and Wishbone ack in wb_des_ctrl.

Verification
REQ-030 Reset then read all 8 offsets -> every read 32'h0, each ack exactly one cycle.
REQ-031 Write KEY=64'h133457799BBCDFF1, DIN=64'h0123456789ABCDEF, CTRL=1; core model done after 16 cycles with 64'h85E813540F0AB405 -> one des_start_o pulse, BUSY=1 until done, DOUT reads 85E813540F0AB405, STATUS=2.
REQ-032 Write KEY_LO=32'hFFFFFFFF with sel=4'b0011 over 0 -> reads 32'h0000FFFF.
REQ-033 Write DIN_LO=32'h1 while BUSY, then CTRL=1 -> DIN unchanged, no second des_start_o.
REQ-034 WB_DES_IRQ_EN defined, IE=1, run op -> irq_o rises after done; write STATUS=2 -> irq_o and DONE clear; undefined -> irq_o stays 0.
REQ-035 Assert wb_rst_i during WAIT, then pulse des_done_i -> STATUS=0, DOUT=0, FSM IDLE.

Source files
------------

// File: rtl/wb_des_pkg.sv
// Shared constants for the Wishbone DES controller: register map, CTRL/STATUS
// bit positions, FSM encoding and the default register window base.
package wb_des_pkg;

    localparam logic [31:0] BASE_ADDR_DEFAULT = 32'h3000_0000;

    localparam logic [2:0] OFF_KEY_LO  = 3'd0;
    localparam logic [2:0] OFF_KEY_HI  = 3'd1;
    localparam logic [2:0] OFF_DIN_LO  = 3'd2;
    localparam logic [2:0] OFF_DIN_HI  = 3'd3;
    localparam logic [2:0] OFF_CTRL    = 3'd4;
    localparam logic [2:0] OFF_STATUS  = 3'd5;
    localparam logic [2:0] OFF_DOUT_LO = 3'd6;
    localparam logic [2:0] OFF_DOUT_HI = 3'd7;

    localparam int CTRL_START   = 0;
    localparam int CTRL_DECRYPT = 1;
    localparam int CTRL_IE      = 2;

    localparam int STAT_BUSY = 0;
    localparam int STAT_DONE = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2
    } des_state_t;

    // Merge new_val into old_val only on the byte lanes enabled in be.
    function automatic logic [31:0] apply_be(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
        logic [31:0] merged;
        merged = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) merged[b*8 +: 8] = new_val[b*8 +: 8];
        end
        return merged;
    endfunction

endpackage

// File: rtl/wb_des_regfile.sv
// Byte-enabled KEY/DIN storage plus the DOUT capture register for the DES
// controller; the caller decides when writes are permitted.
module wb_des_regfile
    import wb_des_pkg::*;
(
    input  logic        clock,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_off,
    input  logic [31:0] wr_data,
    input  logic [3:0]  wr_sel,
    input  logic        dout_load,
    input  logic [63:0] dout_in,
    output logic [63:0] key,
    output logic [63:0] din,
    output logic [63:0] dout
);

    logic [31:0] key_lo, key_hi, din_lo, din_hi;
    logic [63:0] dout_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            key_lo <= '0;
            key_hi <= '0;
            din_lo <= '0;
            din_hi <= '0;
            dout_q <= '0;
        end else begin
            if (wr_en) begin
                case (wr_off)
                    OFF_KEY_LO: key_lo <= apply_be(key_lo, wr_data, wr_sel);
                    OFF_KEY_HI: key_hi <= apply_be(key_hi, wr_data, wr_sel);
                    OFF_DIN_LO: din_lo <= apply_be(din_lo, wr_data, wr_sel);
                    OFF_DIN_HI: din_hi <= apply_be(din_hi, wr_data, wr_sel);
                    default: ;
                endcase
            end
            if (dout_load) dout_q <= dout_in;
        end
    end

    assign key  = {key_hi, key_lo};
    assign din  = {din_hi, din_lo};
    assign dout = dout_q;

endmodule

// File: rtl/wb_des_ctrl.sv
// Wishbone classic slave front-end that loads and launches an external DES core.
// Define WB_DES_IRQ_EN to build the completion interrupt (CTRL.IE and irq_o).
module wb_des_ctrl
    import wb_des_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = BASE_ADDR_DEFAULT
)
(
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    output logic [63:0] des_key_o,
    output logic [63:0] des_data_o,
    output logic        des_decrypt_o,
    output logic        des_start_o,
    input  logic        des_done_i,
    input  logic [63:0] des_result_i,
    output logic        irq_o
);

    des_state_t  state_q, state_d;
    logic        ack_q;
    logic [31:0] rdata_q, read_mux;
    logic        decrypt_q, done_q, ie_bit;
    logic [63:0] dout;
    logic [2:0]  off;
    logic        req_hit, access, wr_acc, busy;
    logic        ctrl_wr, status_wr, start_req, done_evt;
    logic        unused_adr_bits;

    assign off       = wbs_adr_i[4:2];
    assign req_hit   = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:5] == BASE_ADDR[31:5]);
    // A select still held during its own ack cycle is not taken as a new request.
    assign access    = req_hit & ~ack_q;
    assign wr_acc    = access & wbs_we_i;
    assign busy      = (state_q != ST_IDLE);
    assign ctrl_wr   = wr_acc & (off == OFF_CTRL) & wbs_sel_i[0];
    assign status_wr = wr_acc & (off == OFF_STATUS) & wbs_sel_i[0];
    assign start_req = ctrl_wr & wbs_dat_i[CTRL_START] & ~busy;
    assign done_evt  = (state_q == ST_WAIT) & des_done_i;

    assign unused_adr_bits = &{1'b0, wbs_adr_i[1:0]};

    wb_des_regfile u_regfile (
        .clock     (wb_clk_i),
        .reset     (wb_rst_i),
        .wr_en     (wr_acc & ~busy),
        .wr_off    (off),
        .wr_data   (wbs_dat_i),
        .wr_sel    (wbs_sel_i),
        .dout_load (done_evt),
        .dout_in   (des_result_i),
        .key       (des_key_o),
        .din       (des_data_o),
        .dout      (dout)
    );

    always_comb begin
        state_d     = state_q;
        des_start_o = 1'b0;
        case (state_q)
            ST_IDLE:  if (start_req) state_d = ST_START;
            ST_START: begin
                des_start_o = 1'b1;
                state_d     = ST_WAIT;
            end
            ST_WAIT:  if (des_done_i) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        read_mux = '0;
        case (off)
            OFF_KEY_LO:  read_mux = des_key_o[31:0];
            OFF_KEY_HI:  read_mux = des_key_o[63:32];
            OFF_DIN_LO:  read_mux = des_data_o[31:0];
            OFF_DIN_HI:  read_mux = des_data_o[63:32];
            OFF_CTRL: begin
                read_mux[CTRL_DECRYPT] = decrypt_q;
                read_mux[CTRL_IE]      = ie_bit;
            end
            OFF_STATUS: begin
                read_mux[STAT_BUSY] = busy;
                read_mux[STAT_DONE] = done_q;
            end
            OFF_DOUT_LO: read_mux = dout[31:0];
            OFF_DOUT_HI: read_mux = dout[63:32];
            default:     read_mux = '0;
        endcase
    end

    // Completion sets DONE ahead of any clear arriving on the same edge.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= ST_IDLE;
            ack_q     <= 1'b0;
            rdata_q   <= '0;
            decrypt_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= access;
            rdata_q <= (access & ~wbs_we_i) ? read_mux : '0;
            if (ctrl_wr & ~busy) decrypt_q <= wbs_dat_i[CTRL_DECRYPT];
            if (done_evt)
                done_q <= 1'b1;
            else if (start_req)
                done_q <= 1'b0;
            else if (status_wr & wbs_dat_i[STAT_DONE])
                done_q <= 1'b0;
        end
    end

`ifdef WB_DES_IRQ_EN
    logic ie_q, irq_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            ie_q  <= 1'b0;
            irq_q <= 1'b0;
        end else begin
            if (ctrl_wr) ie_q <= wbs_dat_i[CTRL_IE];
            irq_q <= done_q & ie_q;
        end
    end

    assign ie_bit = ie_q;
    assign irq_o  = irq_q;
`else
    assign ie_bit = 1'b0;
    assign irq_o  = 1'b0;
`endif

    assign wbs_ack_o     = ack_q;
    assign wbs_dat_o     = rdata_q;
    assign des_decrypt_o = decrypt_q;

endmodule

// File: tb/tb_wb_des_ctrl.sv
// Directed self-checking bench for wb_des_ctrl with a simple DES core model
// that answers each start pulse with a fixed result after 16 cycles.
module tb_wb_des_ctrl;

    localparam logic [31:0] BASE   = 32'h3000_0000;
    localparam logic [63:0] RESULT = 64'h85E8_1354_0F0A_B405;
    localparam logic [2:0]  O_KEY_LO = 3'd0, O_KEY_HI = 3'd1, O_DIN_LO = 3'd2, O_DIN_HI = 3'd3;
    localparam logic [2:0]  O_CTRL = 3'd4, O_STATUS = 3'd5, O_DOUT_LO = 3'd6, O_DOUT_HI = 3'd7;
`ifdef WB_DES_IRQ_EN
    localparam logic        IRQ_BUILD = 1'b1;
`else
    localparam logic        IRQ_BUILD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [3:0]  sel = 4'h0;
    logic [31:0] adr = '0, wdat = '0;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;
    logic [63:0] des_key_o, des_data_o;
    logic        des_decrypt_o, des_start_o, irq_o;
    logic        des_done_i = 1'b0;
    logic [63:0] des_result_i = '0;

    int checks = 0;
    int failures = 0;
    int start_count = 0;
    int done_count = 0;

    always #5 clk = ~clk;

    wb_des_ctrl dut (
        .wb_clk_i      (clk),
        .wb_rst_i      (rst),
        .wbs_cyc_i     (cyc),
        .wbs_stb_i     (stb),
        .wbs_we_i      (we),
        .wbs_sel_i     (sel),
        .wbs_adr_i     (adr),
        .wbs_dat_i     (wdat),
        .wbs_ack_o     (wbs_ack_o),
        .wbs_dat_o     (wbs_dat_o),
        .des_key_o     (des_key_o),
        .des_data_o    (des_data_o),
        .des_decrypt_o (des_decrypt_o),
        .des_start_o   (des_start_o),
        .des_done_i    (des_done_i),
        .des_result_i  (des_result_i),
        .irq_o         (irq_o)
    );

    // Start pulses are counted on every falling edge, independent of the core model.
    initial begin
        forever begin
            @(negedge clk);
            if (des_start_o) start_count++;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (des_start_o) begin
                repeat (16) @(negedge clk);
                des_result_i = RESULT;
                des_done_i   = 1'b1;
                @(negedge clk);
                des_done_i   = 1'b0;
                des_result_i = '0;
                done_count++;
            end
        end
    end

    initial begin
        #1ms;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    // One Wishbone classic access; entered and left on a falling edge.
    task automatic applyStimulus(input logic write, input logic [2:0] off, input logic [31:0] data,
                                 input logic [3:0] be, output logic [31:0] rdata);
        int waited;
        cyc = 1'b1; stb = 1'b1; we = write;
        adr = BASE + {27'd0, off, 2'b00};
        wdat = data; sel = be;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (!wbs_ack_o && waited < 4);
        checkOutput("ack_latency", 64'(waited), 64'd1);
        rdata = wbs_dat_o;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        checkOutput("ack_single", 64'(wbs_ack_o), 64'd0);
        checkOutput("dat_idle", 64'(wbs_dat_o), 64'd0);
    endtask

    task automatic waitIdle(input string tag);
        logic [31:0] st;
        int n;
        n = 0;
        do begin
            applyStimulus(1'b0, O_STATUS, '0, 4'hF, st);
            n++;
        end while (st[0] && n < 20);
        checkOutput(tag, 64'(st[0]), 64'd0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        ack_seen;
        int          s0, d0, n;

        @(negedge clk);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_ack", 64'(wbs_ack_o), 64'd0);
        checkOutput("rst_start", 64'(des_start_o), 64'd0);
        checkOutput("rst_irq", 64'(irq_o), 64'd0);
        checkOutput("rst_key", des_key_o, 64'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 3'(i), '0, 4'hF, rd);
            checkOutput($sformatf("rst_read%0d", i), 64'(rd), 64'd0);
        end

        applyStimulus(1'b1, O_KEY_LO, 32'hFFFF_FFFF, 4'b0011, rd);
        applyStimulus(1'b0, O_KEY_LO, '0, 4'hF, rd);
        checkOutput("be_0011", 64'(rd), 64'h0000_FFFF);
        checkOutput("be_key_out", des_key_o, 64'h0000_0000_0000_FFFF);
        applyStimulus(1'b1, O_KEY_LO, 32'hAABB_CCDD, 4'b1100, rd);
        applyStimulus(1'b0, O_KEY_LO, '0, 4'hF, rd);
        checkOutput("be_1100", 64'(rd), 64'hAABB_FFFF);

        cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF;
        adr = BASE + 32'h20;
        ack_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            ack_seen = ack_seen | wbs_ack_o;
        end
        cyc = 1'b0; stb = 1'b0;
        checkOutput("outside_window", 64'(ack_seen), 64'd0);
        @(negedge clk);

        applyStimulus(1'b1, O_CTRL, 32'h6, 4'hF, rd);
        applyStimulus(1'b0, O_CTRL, '0, 4'hF, rd);
        checkOutput("ctrl_rw", 64'(rd), IRQ_BUILD ? 64'h6 : 64'h2);
        checkOutput("decrypt_out", 64'(des_decrypt_o), 64'd1);
        applyStimulus(1'b1, O_CTRL, 32'h0, 4'hF, rd);

        applyStimulus(1'b1, O_KEY_LO, 32'h9BBC_DFF1, 4'hF, rd);
        applyStimulus(1'b1, O_KEY_HI, 32'h1334_5779, 4'hF, rd);
        applyStimulus(1'b1, O_DIN_LO, 32'h89AB_CDEF, 4'hF, rd);
        applyStimulus(1'b1, O_DIN_HI, 32'h0123_4567, 4'hF, rd);
        checkOutput("key_out", des_key_o, 64'h1334_5779_9BBC_DFF1);
        checkOutput("din_out", des_data_o, 64'h0123_4567_89AB_CDEF);
        s0 = start_count;
        applyStimulus(1'b1, O_CTRL, 32'h1, 4'hF, rd);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("status_busy", 64'(rd), 64'h1);
        waitIdle("op1_idle");
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("op1_status", 64'(rd), 64'h2);
        applyStimulus(1'b0, O_DOUT_LO, '0, 4'hF, rd);
        checkOutput("op1_dout_lo", 64'(rd), 64'h0F0A_B405);
        applyStimulus(1'b0, O_DOUT_HI, '0, 4'hF, rd);
        checkOutput("op1_dout_hi", 64'(rd), 64'h85E8_1354);
        checkOutput("op1_starts", 64'(start_count - s0), 64'd1);
        applyStimulus(1'b0, O_CTRL, '0, 4'hF, rd);
        checkOutput("ctrl_start_reads0", 64'(rd), 64'h0);
        applyStimulus(1'b1, O_DOUT_LO, 32'h1234_5678, 4'hF, rd);
        applyStimulus(1'b0, O_DOUT_LO, '0, 4'hF, rd);
        checkOutput("dout_ro", 64'(rd), 64'h0F0A_B405);

        s0 = start_count;
        applyStimulus(1'b1, O_CTRL, 32'h1, 4'hF, rd);
        applyStimulus(1'b1, O_DIN_LO, 32'h1, 4'hF, rd);
        applyStimulus(1'b1, O_CTRL, 32'h3, 4'hF, rd);
        applyStimulus(1'b1, O_KEY_HI, 32'h0, 4'hF, rd);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("busy_done_cleared", 64'(rd), 64'h1);
        applyStimulus(1'b0, O_DIN_LO, '0, 4'hF, rd);
        checkOutput("busy_din_locked", 64'(rd), 64'h89AB_CDEF);
        applyStimulus(1'b0, O_CTRL, '0, 4'hF, rd);
        checkOutput("busy_ctrl_locked", 64'(rd), 64'h0);
        checkOutput("busy_key_locked", des_key_o, 64'h1334_5779_9BBC_DFF1);
        waitIdle("op2_idle");
        checkOutput("op2_starts", 64'(start_count - s0), 64'd1);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("op2_status", 64'(rd), 64'h2);

        applyStimulus(1'b1, O_STATUS, 32'h0, 4'hF, rd);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("w0_keeps_done", 64'(rd), 64'h2);
        applyStimulus(1'b1, O_STATUS, 32'h2, 4'hF, rd);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("w1c_done", 64'(rd), 64'h0);

        applyStimulus(1'b1, O_CTRL, 32'h4, 4'hF, rd);
        applyStimulus(1'b1, O_CTRL, 32'h5, 4'hF, rd);
        checkOutput("irq_busy", 64'(irq_o), 64'd0);
        waitIdle("op3_idle");
        @(negedge clk);
        checkOutput("irq_after_done", 64'(irq_o), 64'(IRQ_BUILD));
        applyStimulus(1'b1, O_STATUS, 32'h2, 4'hF, rd);
        checkOutput("irq_cleared", 64'(irq_o), 64'd0);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("irq_status_clr", 64'(rd), 64'h0);

        d0 = done_count;
        applyStimulus(1'b1, O_CTRL, 32'h1, 4'hF, rd);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checkOutput("midrst_start", 64'(des_start_o), 64'd0);
        checkOutput("midrst_irq", 64'(irq_o), 64'd0);
        n = 0;
        while (done_count == d0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("midrst_done_pulsed", 64'(done_count - d0), 64'd1);
        @(negedge clk);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("midrst_status", 64'(rd), 64'h0);
        applyStimulus(1'b0, O_DOUT_LO, '0, 4'hF, rd);
        checkOutput("midrst_dout_lo", 64'(rd), 64'h0);
        applyStimulus(1'b0, O_DOUT_HI, '0, 4'hF, rd);
        checkOutput("midrst_dout_hi", 64'(rd), 64'h0);
        applyStimulus(1'b0, O_CTRL, '0, 4'hF, rd);
        checkOutput("midrst_ctrl", 64'(rd), 64'h0);
        checkOutput("midrst_key", des_key_o, 64'd0);

        s0 = start_count;
        applyStimulus(1'b1, O_CTRL, 32'h1, 4'hF, rd);
        waitIdle("op4_idle");
        checkOutput("op4_starts", 64'(start_count - s0), 64'd1);
        applyStimulus(1'b0, O_STATUS, '0, 4'hF, rd);
        checkOutput("op4_status", 64'(rd), 64'h2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
